// File: rtl/i2c_target.sv
// i2c_target: single-address I2C target with open-drain scl/sda and a one-byte transmit buffer.
// Optional macro I2C_TARGET_CLOCK_STRETCH_EN: hold scl low on transmit underrun until tx_load.
module i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       reset_n,
  inout  tri         scl,
  inout  tri         sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_empty,
  output logic       tx_req,
  output logic       start_tick,
  output logic       stop_tick,
  output logic       busy,
  output logic       rd_mode
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  state_t     state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shreg, shreg_n;
  logic [7:0] tx_buf, tx_buf_n;
  logic [7:0] rx_data_n, rx_byte;
  logic       ack_phase, ack_phase_n;
  logic       sda_oe, sda_oe_n;
  logic       rx_valid_n, tx_empty_n, tx_req_n, start_tick_n, stop_tick_n;
  logic       busy_n, rd_mode_n, reload;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
  logic       scl_hold, scl_hold_n;
`endif

  // [0] first sync stage, [1] synchronized value, [2] delayed copy for edge detection
  logic [2:0] scl_p, sda_p;
  logic       scl_rise, scl_fall, start_ev, stop_ev, sda_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_p <= '1;
      sda_p <= '1;
    end else begin
      scl_p <= {scl_p[1:0], scl};
      sda_p <= {sda_p[1:0], sda};
    end
  end

  assign sda_s    = sda_p[1];
  assign scl_rise = scl_p[1] & ~scl_p[2];
  assign scl_fall = ~scl_p[1] & scl_p[2];
  assign start_ev = scl_p[1] & scl_p[2] & ~sda_p[1] & sda_p[2];
  assign stop_ev  = scl_p[1] & scl_p[2] & sda_p[1] & ~sda_p[2];
  assign rx_byte  = {shreg[6:0], sda_s};

  assign sda = sda_oe ? 1'b0 : 1'bz;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
  assign scl = scl_hold ? 1'b0 : 1'bz;
`else
  assign scl = 1'bz;
`endif

  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    shreg_n      = shreg;
    tx_buf_n     = tx_buf;
    rx_data_n    = rx_data;
    ack_phase_n  = ack_phase;
    sda_oe_n     = sda_oe;
    rx_valid_n   = 1'b0;
    tx_empty_n   = tx_empty;
    tx_req_n     = 1'b0;
    start_tick_n = 1'b0;
    stop_tick_n  = 1'b0;
    busy_n       = busy;
    rd_mode_n    = rd_mode;
    reload       = 1'b0;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
    scl_hold_n   = scl_hold;
`endif

    case (state)
      ADDR: if (scl_rise) begin
        shreg_n   = rx_byte;
        bit_cnt_n = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          if (rx_byte[7:1] == TARGET_ADDR) begin
            state_n     = ADDR_ACK;
            rd_mode_n   = rx_byte[0];
            busy_n      = 1'b1;
            ack_phase_n = 1'b0;
          end else begin
            state_n = WAIT_STOP;
            busy_n  = 1'b0;
          end
        end
      end
      // ack_phase marks that the ACK low is already on the bus
      ADDR_ACK, WR_ACK: if (scl_fall) begin
        if (!ack_phase) begin
          ack_phase_n = 1'b1;
          sda_oe_n    = 1'b1;
        end else begin
          ack_phase_n = 1'b0;
          sda_oe_n    = 1'b0;
          bit_cnt_n   = '0;
          if (state == ADDR_ACK && rd_mode) reload = 1'b1;
          else                              state_n = WR_DATA;
        end
      end
      WR_DATA: if (scl_rise) begin
        shreg_n   = rx_byte;
        bit_cnt_n = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_data_n   = rx_byte;
          rx_valid_n  = 1'b1;
          state_n     = WR_ACK;
          ack_phase_n = 1'b0;
        end
      end
      RD_DATA:
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
        // scl_hold here means the shifter is still waiting for a buffer load
        if (scl_hold) begin
          if (!tx_empty) begin
            scl_hold_n = 1'b0;
            shreg_n    = tx_buf;
            sda_oe_n   = ~tx_buf[7];
            tx_req_n   = 1'b1;
            tx_empty_n = 1'b1;
          end
        end else
`endif
        if (scl_fall) begin
          if (bit_cnt == 3'd7) begin
            sda_oe_n    = 1'b0;
            state_n     = RD_ACK;
            ack_phase_n = 1'b0;
          end else begin
            shreg_n   = {shreg[6:0], 1'b1};
            sda_oe_n  = ~shreg[6];
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end
      RD_ACK:
        if (!ack_phase) begin
          if (scl_rise) begin
            if (sda_s) state_n = WAIT_STOP;
            else       ack_phase_n = 1'b1;
          end
        end else if (scl_fall) begin
          ack_phase_n = 1'b0;
          reload      = 1'b1;
        end
      default: ;
    endcase

    if (reload) begin
      state_n   = RD_DATA;
      bit_cnt_n = '0;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
      if (tx_empty) begin
        scl_hold_n = 1'b1;
        sda_oe_n   = 1'b0;
      end else
`endif
      begin
        shreg_n    = tx_empty ? 8'hFF : tx_buf;
        sda_oe_n   = tx_empty ? 1'b0 : ~tx_buf[7];
        tx_req_n   = 1'b1;
        tx_empty_n = 1'b1;
      end
    end

    // Bus conditions override whatever the byte-level logic decided this cycle
    if (stop_ev) begin
      state_n     = IDLE;
      stop_tick_n = 1'b1;
      busy_n      = 1'b0;
      sda_oe_n    = 1'b0;
      rx_valid_n  = 1'b0;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
      scl_hold_n  = 1'b0;
`endif
    end else if (start_ev) begin
      state_n      = ADDR;
      start_tick_n = 1'b1;
      bit_cnt_n    = '0;
      ack_phase_n  = 1'b0;
      sda_oe_n     = 1'b0;
      rx_valid_n   = 1'b0;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
      scl_hold_n   = 1'b0;
`endif
    end

    // A load coinciding with a shifter reload keeps the new byte buffered
    if (tx_load) begin
      tx_buf_n   = tx_data;
      tx_empty_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      tx_buf     <= '1;
      rx_data    <= '0;
      ack_phase  <= 1'b0;
      sda_oe     <= 1'b0;
      rx_valid   <= 1'b0;
      tx_empty   <= 1'b1;
      tx_req     <= 1'b0;
      start_tick <= 1'b0;
      stop_tick  <= 1'b0;
      busy       <= 1'b0;
      rd_mode    <= 1'b0;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
      scl_hold   <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shreg      <= shreg_n;
      tx_buf     <= tx_buf_n;
      rx_data    <= rx_data_n;
      ack_phase  <= ack_phase_n;
      sda_oe     <= sda_oe_n;
      rx_valid   <= rx_valid_n;
      tx_empty   <= tx_empty_n;
      tx_req     <= tx_req_n;
      start_tick <= start_tick_n;
      stop_tick  <= stop_tick_n;
      busy       <= busy_n;
      rd_mode    <= rd_mode_n;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
      scl_hold   <= scl_hold_n;
`endif
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Testbench for i2c_target: bit-banged open-drain master, event scoreboard for the tick outputs.
module tb_i2c_target;

  localparam int unsigned Q         = 20;   // clk cycles per quarter SCL period
  localparam int unsigned SCL_LIMIT = 4000;

  typedef enum logic [1:0] {EV_START, EV_STOP, EV_RX, EV_TXREQ} ev_kind_t;
  typedef struct packed {
    ev_kind_t   kind;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] tx_data;
  logic       tx_load;
  logic [7:0] rx_data;
  logic       rx_valid, tx_empty, tx_req, start_tick, stop_tick, busy, rd_mode;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  wire        scl_bus, sda_bus;

  int tests = 0;
  int fails = 0;
  ev_t exp_q[$];

  pullup (scl_bus);
  pullup (sda_bus);
  assign scl_bus = m_scl ? 1'bz : 1'b0;
  assign sda_bus = m_sda ? 1'bz : 1'b0;

  always #5 clk = ~clk;

  i2c_target #(.TARGET_ADDR(7'h42)) dut (
    .clk(clk), .reset_n(reset_n), .scl(scl_bus), .sda(sda_bus),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_load(tx_load),
    .tx_empty(tx_empty), .tx_req(tx_req), .start_tick(start_tick), .stop_tick(stop_tick),
    .busy(busy), .rd_mode(rd_mode)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input ev_kind_t k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input ev_kind_t k, input logic [7:0] d);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL event: got %s data %h, required no event", k.name(), d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || (k == EV_RX && e.data != d)) begin
        fails++;
        $display("FAIL event: got %s data %h, required %s data %h", k.name(), d, e.kind.name(), e.data);
      end
    end
  endtask

  // Monitor: every tick the DUT raises must match the next expected event
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (start_tick) pop_cmp(EV_START, 8'h00);
      if (stop_tick)  pop_cmp(EV_STOP, 8'h00);
      if (rx_valid)   pop_cmp(EV_RX, rx_data);
      if (tx_req)     pop_cmp(EV_TXREQ, 8'h00);
    end
  end

  task automatic q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic release_scl();
    bit ok;
    ok = 1'b0;
    m_scl = 1'b1;
    for (int i = 0; i < SCL_LIMIT; i++) begin
      @(negedge clk);
      if (scl_bus === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL scl_release: scl %b after %0d clk, required 1", scl_bus, SCL_LIMIT);
    end
  endtask

  task automatic bus_bit(input logic b, output logic s);
    m_sda = b;
    q();
    release_scl();
    q();
    s = sda_bus;
    q();
    m_scl = 1'b0;
    q();
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    q();
    release_scl();
    q();
    m_sda = 1'b0;
    q();
    m_scl = 1'b0;
    q();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    q();
    release_scl();
    q();
    m_sda = 1'b1;
    q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
    bus_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic mack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      d[i] = s;
    end
    bus_bit(~mack, s);
  endtask

  task automatic tx_push(input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  initial begin
    logic       ack, s;
    logic [7:0] d;
    reset_n = 1'b0;
    tx_data = '0;
    tx_load = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_flags", {rx_valid, tx_req, start_tick, stop_tick, busy, rd_mode, tx_empty}, 8'h01);
    check("rst_lines", {scl_bus, sda_bus}, 8'h03);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // Write 0xA5 to 0x42
    expect_ev(EV_START, 8'h00);
    i2c_start();
    write_byte(8'h84, ack);
    check("wr_addr_ack", ack, 1'b1);
    check("wr_busy", busy, 1'b1);
    check("wr_rd_mode", rd_mode, 1'b0);
    expect_ev(EV_RX, 8'hA5);
    write_byte(8'hA5, ack);
    check("wr_data_ack", ack, 1'b1);
    check("wr_rx_data", rx_data, 8'hA5);
    check("wr_busy_before_stop", busy, 1'b1);
    expect_ev(EV_STOP, 8'h00);
    i2c_stop();
    check("wr_busy_after_stop", busy, 1'b0);

    // Address mismatch
    expect_ev(EV_START, 8'h00);
    i2c_start();
    write_byte(8'h86, ack);
    check("mm_addr_nack", ack, 1'b0);
    check("mm_busy", busy, 1'b0);
    write_byte(8'h11, ack);
    check("mm_data_nack", ack, 1'b0);
    expect_ev(EV_STOP, 8'h00);
    i2c_stop();

    // Read two bytes; second preload overwrites the first
    tx_push(8'h11);
    tx_push(8'h3C);
    check("rd_tx_full", tx_empty, 1'b0);
    expect_ev(EV_START, 8'h00);
    i2c_start();
    expect_ev(EV_TXREQ, 8'h00);
    write_byte(8'h85, ack);
    check("rd_addr_ack", ack, 1'b1);
    check("rd_rd_mode", rd_mode, 1'b1);
    check("rd_tx_empty", tx_empty, 1'b1);
    tx_push(8'hC3);
    expect_ev(EV_TXREQ, 8'h00);
    read_byte(d, 1'b1);
    check("rd_byte0", d, 8'h3C);
    read_byte(d, 1'b0);
    check("rd_byte1", d, 8'hC3);
    check("rd_busy_wait_stop", busy, 1'b1);
    expect_ev(EV_STOP, 8'h00);
    i2c_stop();
    check("rd_busy_after_stop", busy, 1'b0);

    // Repeated START: write then read, no STOP between
    expect_ev(EV_START, 8'h00);
    i2c_start();
    write_byte(8'h84, ack);
    expect_ev(EV_RX, 8'h01);
    write_byte(8'h01, ack);
    check("sr_wr_ack", ack, 1'b1);
    check("sr_rd_mode0", rd_mode, 1'b0);
    tx_push(8'h77);
    expect_ev(EV_START, 8'h00);
    i2c_start();
    expect_ev(EV_TXREQ, 8'h00);
    write_byte(8'h85, ack);
    check("sr_rd_ack", ack, 1'b1);
    check("sr_rd_mode1", rd_mode, 1'b1);
    read_byte(d, 1'b0);
    check("sr_byte", d, 8'h77);
    expect_ev(EV_STOP, 8'h00);
    i2c_stop();

    // Underrun: empty buffer at the reload
    expect_ev(EV_START, 8'h00);
    i2c_start();
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
    write_byte(8'h85, ack);
    check("ur_addr_ack", ack, 1'b1);
    fork
      read_byte(d, 1'b0);
      begin
        repeat (6 * Q) @(negedge clk);
        check("ur_scl_held", scl_bus, 1'b0);
        expect_ev(EV_TXREQ, 8'h00);
        tx_push(8'h5A);
      end
    join
    check("ur_byte", d, 8'h5A);
`else
    expect_ev(EV_TXREQ, 8'h00);
    write_byte(8'h85, ack);
    check("ur_addr_ack", ack, 1'b1);
    read_byte(d, 1'b0);
    check("ur_byte", d, 8'hFF);
`endif
    expect_ev(EV_STOP, 8'h00);
    i2c_stop();

    // STOP after 4 data bits: partial byte dropped
    expect_ev(EV_START, 8'h00);
    i2c_start();
    write_byte(8'h84, ack);
    bus_bit(1'b1, s);
    bus_bit(1'b0, s);
    bus_bit(1'b1, s);
    bus_bit(1'b0, s);
    expect_ev(EV_STOP, 8'h00);
    i2c_stop();
    check("ps_busy", busy, 1'b0);
    check("ps_lines", {scl_bus, sda_bus}, 8'h03);

    // Reset asserted while driving a 0 data bit
    tx_push(8'h00);
    expect_ev(EV_START, 8'h00);
    i2c_start();
    expect_ev(EV_TXREQ, 8'h00);
    write_byte(8'h85, ack);
    bus_bit(1'b1, s);
    check("rr_bit7", s, 1'b0);
    bus_bit(1'b1, s);
    check("rr_sda_driven", sda_bus, 1'b0);
    #2 reset_n = 1'b0;
    #1 check("rr_sda_released", sda_bus, 1'b1);
    repeat (3) @(negedge clk);
    m_scl = 1'b1;
    @(negedge clk);
    check("rr_scl_released", scl_bus, 1'b1);
    check("rr_flags", {rx_valid, busy, rd_mode, tx_empty}, 8'h01);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // Post-reset write proves the target is back in IDLE
    expect_ev(EV_START, 8'h00);
    i2c_start();
    write_byte(8'h84, ack);
    check("pr_addr_ack", ack, 1'b1);
    expect_ev(EV_RX, 8'h5E);
    write_byte(8'h5E, ack);
    check("pr_rx_data", rx_data, 8'h5E);
    expect_ev(EV_STOP, 8'h00);
    i2c_stop();

    repeat (10) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pending_events: got %0d outstanding, required 0 (next %s)",
               exp_q.size(), exp_q[0].kind.name());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
